lsu: RTL and testbench
======================

# lsu

Load/store unit between the core datapath and the data-memory port. It takes the memory request generated for a decoded LOAD/STORE (request, write enable, 3-bit size code, ALU-computed address, rs2 data), stalls the core while the access is in flight, and drives a byte-enable memory interface. For loads it returns the aligned and sign/zero-extended result for register write-back.

## Interface
- No parameters. Data and address width is fixed at 32.
- clk_i in 1: clock. Sole clock.
- rst_i in 1: synchronous, active-high reset.
- core_req_i in 1: memory instruction present; held high until core_stall_o is low.
- core_we_i in 1: 1 = store, 0 = load.
- core_size_i in 3: LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
- core_addr_i in 32: byte address.
- core_wd_i in 32: store data (rs2).
- core_rd_o out 32: extended load result; valid in the DONE cycle.
- core_stall_o out 1: freeze the core.
- core_err_o out 1: one-cycle pulse in DONE for a misaligned address or unsupported size code.
- mem_req_o out 1: memory request.
- mem_we_o out 1: memory write.
- mem_be_o out 4: byte enables.
- mem_addr_o out 32: byte address, passed through unmodified.
- mem_wd_o out 32: lane-replicated write data.
- mem_rd_i in 32: read word.
- mem_ready_i in 1: memory completes the access this cycle.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If core_req_i=1, latch we, size, addr and wd.
  - If the request is legal, go to REQ. Otherwise go to DONE with the error flag set.
- REQ:
  - mem_req_o=1. mem_we_o, mem_be_o, mem_addr_o and mem_wd_o are driven from the latched values and held stable.
  - On mem_ready_i=1: for a load, register the extracted result; go to DONE.
  - If mem_ready_i=0, stay in REQ.
- DONE:
  - core_stall_o=0 and core_rd_o is valid. core_err_o=1 if the error flag is set.
  - Always return to IDLE next cycle. core_req_i still high in DONE is the same instruction and is ignored.
- core_stall_o = core_req_i AND (state != DONE). This is combinational, so the core freezes in the cycle the request appears.
- Misaligned accesses:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - Size codes 3, 6 and 7 are treated as errors.
  - An error issues no memory request and forces core_rd_o=0.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Write data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load extraction (lane selected by the latched addr[1:0]):
  - B: sign-extend byte.
  - BU: zero-extend byte.
  - H: sign-extend half (addr[1]).
  - HU: zero-extend half.
  - W: full word.
- mem_rd_i is sampled only when state=REQ and mem_ready_i=1; it is ignored in all other cycles.
- Store: core_rd_o=0.

## Timing
- Reset:
  - state=IDLE; all latched registers are cleared to 0.
  - core_rd_o=0, core_err_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0.
  - core_stall_o follows core_req_i.
- Outside REQ, mem_req_o=0, mem_we_o=0 and mem_be_o=0.
- Minimum latency (mem_ready_i high in the first REQ cycle): request in cycle 0 (IDLE, stall=1), cycle 1 in REQ, cycle 2 in DONE (stall=0). Three cycles total.
- Each wait cycle with mem_ready_i=0 adds one cycle in REQ.
- Misaligned request: IDLE then DONE; two cycles, no mem_req_o.
- Back-to-back requests: the next instruction's core_req_i is seen in IDLE the cycle after DONE. There is no overlap and at most one outstanding access.
- Reset while in REQ abandons the access; mem_req_o drops in the next cycle. The memory must tolerate a dropped request.

## Structure
- LDST_* size constants come from the existing decoder_pkg.
- A new lsu_pkg holds the state enum (lsu_state_t: IDLE, REQ, DONE) and the functions for byte-enable and write-data replication.
- One combinational sub-module, lsu_load_align: inputs are word, addr[1:0] and size; output is the 32-bit extended result.

## Test plan
- LW at 0x100, mem_rd_i=0xDEADBEEF, ready in the first REQ cycle -> mem_be_o=1111; core_rd_o=0xDEADBEEF in cycle 2; stall high in cycles 0–1 and low in cycle 2.
- LB at 0x103 and LBU at 0x103, word 0x80FF7F01 -> be=1000; results 0xFFFFFF80 (LB) and 0x00000080 (LBU).
- SH at 0x202, wd=0x1234ABCD, ready after 3 wait cycles -> mem_we_o=1, be=1100, mem_wd_o=0xABCDABCD; mem_req_o stays high with stable outputs for 4 cycles.
- LW at 0x101, then SH at 0x203 -> no mem_req_o; core_err_o pulses in DONE; core_rd_o=0; each completes in 2 cycles.
- rst_i asserted during REQ while mem_ready_i=0 -> next cycle IDLE with mem_req_o=0 and all outputs 0; a following LW completes normally.
- Back-to-back SB 0x10 (wd=0xAA) then LBU 0x10 with a memory model -> be=0001, wd=0xAAAAAAAA; load returns 0x000000AA.

Source files
------------

// File: rtl/decoder_pkg.sv
// Decoder-side constants shared with the execute stage.
// Only the load/store size codes are used by the LSU.
package decoder_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

endpackage

// File: rtl/lsu_pkg.sv
// Load/store unit types and helpers.
// Covers legality checking, byte-enable generation and store-lane replication.
package lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } lsu_state_t;

  // Size codes 3, 6 and 7 are never legal; halves and words must be naturally aligned.
  function automatic logic ldst_legal(input logic [2:0] size, input logic [1:0] addr);
    logic ok;
    case (size)
      decoder_pkg::LDST_B, decoder_pkg::LDST_BU: ok = 1'b1;
      decoder_pkg::LDST_H, decoder_pkg::LDST_HU: ok = ~addr[0];
      decoder_pkg::LDST_W:                       ok = (addr == 2'b00);
      default:                                   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] ldst_be(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      decoder_pkg::LDST_B, decoder_pkg::LDST_BU: be = 4'b0001 << addr;
      decoder_pkg::LDST_H, decoder_pkg::LDST_HU: be = 4'b0011 << {addr[1], 1'b0};
      decoder_pkg::LDST_W:                       be = 4'b1111;
      default:                                   be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] ldst_wdata(input logic [2:0] size,
                                                   input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] w;
    case (size)
      decoder_pkg::LDST_B, decoder_pkg::LDST_BU: w = {4{wd[7:0]}};
      decoder_pkg::LDST_H, decoder_pkg::LDST_HU: w = {2{wd[15:0]}};
      default:                                   w = wd;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word lane of a read word and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
  import decoder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  size,
  output logic [31:0] result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = 8'(word >> {addr, 3'b000});
    half_s = addr[1] ? word[31:16] : word[15:0];
    result = '0;
    case (size)
      LDST_B:  result = 32'(byte_s);
      LDST_BU: result = {24'd0, byte_s};
      LDST_H:  result = 32'(half_s);
      LDST_HU: result = {16'd0, half_s};
      LDST_W:  result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access at a time, stalls the core until
// the memory port completes, then returns the extended load result.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] load_data;

  lsu_load_align u_align (
    .word   (mem_rd_i),
    .addr   (mem_addr_o[1:0]),
    .size   (size_q),
    .result (load_data)
  );

  // The core must freeze in the very cycle its request appears.
  assign core_stall_o = core_req_i && (state != DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= '0;
      core_rd_o  <= '0;
      core_err_o <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_be_o   <= '0;
      mem_addr_o <= '0;
      mem_wd_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          core_err_o <= 1'b0;
          if (core_req_i) begin
            we_q       <= core_we_i;
            size_q     <= core_size_i;
            mem_addr_o <= core_addr_i;
            mem_wd_o   <= ldst_wdata(core_size_i, core_wd_i);
            core_rd_o  <= '0;
            if (ldst_legal(core_size_i, core_addr_i[1:0])) begin
              state     <= REQ;
              mem_req_o <= 1'b1;
              mem_we_o  <= core_we_i;
              mem_be_o  <= ldst_be(core_size_i, core_addr_i[1:0]);
            end else begin
              state      <= DONE;
              core_err_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready_i) begin
            state     <= DONE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_be_o  <= '0;
            core_rd_o <= we_q ? '0 : load_data;
          end
        end
        DONE: begin
          // A request still asserted here belongs to the instruction just finished.
          state      <= IDLE;
          core_err_o <= 1'b0;
          core_rd_o  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a byte-addressed reference memory model.
module tb_lsu;
  import decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, core_err_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
  logic        mem_ready_i;

  always #5 clk = ~clk;

  lsu dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .core_err_o   (core_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wmem [64];   // word memory served to the DUT
  logic [7:0]  bmem [256];  // reference byte memory

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] size);
    case (size)
      LDST_B, LDST_BU: return 1;
      LDST_H, LDST_HU: return 2;
      LDST_W:          return 4;
      default:         return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [2:0] size, input logic [31:0] addr);
    int n = nbytes(size);
    return (n != 0) && ((int'(addr[1:0]) % n) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] addr);
    logic [3:0] be = '0;
    for (int j = 0; j < nbytes(size); j++) be[int'(addr[1:0]) + j] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] w = '0;
    int n = nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr);
    logic [31:0] v = '0;
    for (int j = 0; j < nbytes(size); j++) v[8*j +: 8] = bmem[int'(addr[7:0]) + j];
    if (size == LDST_B && v[7])  v = v | 32'hFFFF_FF00;
    if (size == LDST_H && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    wmem[addr[7:2]] = word;
    for (int j = 0; j < 4; j++) bmem[int'({addr[7:2], 2'b00}) + j] = word[8*j +: 8];
  endtask

  // Runs one instruction from IDLE through DONE and into the following IDLE cycle.
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits);
    bit ok = is_legal(size, addr);
    logic [31:0] exp_rd = (we || !ok) ? 32'd0 : model_load(size, addr);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    #1;
    chk("stall_c0", core_stall_o, 1);
    chk("req_c0", mem_req_o, 0);
    @(posedge clk); #1;
    if (ok) begin
      for (int k = 0; k <= waits; k++) begin
        chk("mem_req", mem_req_o, 1);
        chk("mem_we", mem_we_o, we);
        chk("mem_be", mem_be_o, model_be(size, addr));
        chk("mem_addr", mem_addr_o, addr);
        if (we) chk("mem_wd", mem_wd_o, model_wd(size, wd));
        chk("stall_req", core_stall_o, 1);
        mem_ready_i = (k == waits);
        mem_rd_i = (k == waits && !we) ? wmem[addr[7:2]] : $urandom;
        if (k == waits && mem_we_o)
          for (int i = 0; i < 4; i++)
            if (mem_be_o[i]) wmem[mem_addr_o[7:2]][8*i +: 8] = mem_wd_o[8*i +: 8];
        @(posedge clk); #1;
      end
      mem_ready_i = 1'b0;
      mem_rd_i = $urandom;
      if (we)
        for (int j = 0; j < nbytes(size); j++) bmem[int'(addr[7:0]) + j] = wd[8*j +: 8];
    end
    chk("stall_done", core_stall_o, 0);
    chk("rd_done", core_rd_o, exp_rd);
    chk("err_done", core_err_o, !ok);
    chk("req_done", mem_req_o, 0);
    chk("be_done", mem_be_o, 0);
    core_req_i = 1'b0;
    @(posedge clk); #1;
    chk("err_idle", core_err_o, 0);
    chk("req_idle", mem_req_o, 0);
  endtask

  logic [2:0] legal_sz [5];

  initial begin
    legal_sz[0] = LDST_B; legal_sz[1] = LDST_H; legal_sz[2] = LDST_W;
    legal_sz[3] = LDST_BU; legal_sz[4] = LDST_HU;
    for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);

    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = '0;
    core_addr_i = '0; core_wd_i = '0; mem_rd_i = '0; mem_ready_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rd", core_rd_o, 0);
    chk("rst_err", core_err_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wd", mem_wd_o, 0);
    core_req_i = 1'b1; #1;
    chk("rst_stall_hi", core_stall_o, 1);
    core_req_i = 1'b0; #1;
    chk("rst_stall_lo", core_stall_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    preload(32'h100, 32'hDEADBEEF);
    access(1'b0, LDST_W, 32'h100, 32'h0, 0);
    preload(32'h100, 32'h80FF7F01);
    access(1'b0, LDST_B, 32'h103, 32'h0, 0);
    access(1'b0, LDST_BU, 32'h103, 32'h0, 0);
    access(1'b1, LDST_H, 32'h202, 32'h1234ABCD, 3);
    access(1'b0, LDST_W, 32'h101, 32'h0, 0);
    access(1'b1, LDST_H, 32'h203, 32'h5555AAAA, 0);
    access(1'b0, 3'd3, 32'h0, 32'h0, 0);
    access(1'b1, 3'd7, 32'h8, 32'h0, 0);

    // Reset in the middle of a stalled access.
    core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = LDST_W;
    core_addr_i = 32'h40; core_wd_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("mid_req", mem_req_o, 1);
    core_req_i = 1'b0; rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("abort_req", mem_req_o, 0);
    chk("abort_we", mem_we_o, 0);
    chk("abort_be", mem_be_o, 0);
    chk("abort_addr", mem_addr_o, 0);
    chk("abort_wd", mem_wd_o, 0);
    chk("abort_rd", core_rd_o, 0);
    preload(32'h40, 32'h13579BDF);
    access(1'b0, LDST_W, 32'h40, 32'h0, 1);

    access(1'b1, LDST_B, 32'h10, 32'h000000AA, 0);
    access(1'b0, LDST_BU, 32'h10, 32'h0, 0);

    for (int it = 0; it < 300; it++) begin
      int r = $urandom_range(0, 15);
      logic [2:0] sz;
      sz = (r == 13) ? 3'd3 : (r == 14) ? 3'd6 : (r == 15) ? 3'd7 : legal_sz[r % 5];
      access(1'($urandom), sz, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
